// File: rtl/alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module : alu_issue_ctrl
// Brief  : Valid/ready issue front end for the 32-bit combinational ALU.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [31:0]          in_data,
  output logic [3:0]           alu_control,
  output logic [31:0]          alu_src1,
  output logic [31:0]          alu_src2,
  input  logic [31:0]          alu_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [3:0]           res_op,
  output logic                 res_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_SEL_SRC1 = 2'b00;
  localparam logic [1:0] c_SEL_SRC2 = 2'b01;
  localparam logic [1:0] c_SEL_GO   = 2'b10;

  state_t                 r_state;
  state_t                 w_next;
  logic [31:0]            r_src1;
  logic [31:0]            r_src2;
  logic [3:0]             r_ctrl;
  logic [31:0]            r_res_data;
  logic [3:0]             r_res_op;
  logic                   r_res_err;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   w_beat;
  logic                   w_go_illegal;

  assign w_beat       = (r_state == S_LOAD) && in_valid;
  assign w_go_illegal = (in_data[3:0] == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD: begin
        if (in_valid && (in_sel == c_SEL_GO)) begin
          w_next = w_go_illegal ? S_DONE : S_EXEC;
        end
      end
      S_EXEC:  w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_src1     <= 32'd0;
      r_src2     <= 32'd0;
      r_ctrl     <= 4'd0;
      r_res_data <= 32'd0;
      r_res_op   <= 4'd0;
      r_res_err  <= 1'b0;
      r_count    <= '0;
    end else if (w_beat) begin
      case (in_sel)
        c_SEL_SRC1: r_src1 <= in_data;
        c_SEL_SRC2: r_src2 <= in_data;
        c_SEL_GO: begin
          // An illegal opcode is answered directly without an execute cycle.
          if (w_go_illegal) begin
            r_res_data <= 32'd0;
            r_res_op   <= 4'd0;
            r_res_err  <= 1'b1;
          end else begin
            r_ctrl <= in_data[3:0];
          end
        end
        default: ;
      endcase
    end else if (r_state == S_EXEC) begin
      r_res_data <= alu_result;
      r_res_op   <= r_ctrl;
      r_res_err  <= 1'b0;
      r_ctrl     <= 4'd0;
      if (r_count != {CNT_WIDTH{1'b1}}) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  assign in_ready    = (r_state == S_LOAD);
  assign busy        = (r_state != S_LOAD);
  assign res_valid   = (r_state == S_DONE);
  assign alu_control = (r_state == S_EXEC) ? r_ctrl : 4'd0;
  assign alu_src1    = r_src1;
  assign alu_src2    = r_src2;
  assign res_data    = r_res_data;
  assign res_op      = r_res_op;
  assign res_err     = r_res_err;
  assign op_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_alu_issue_ctrl
// Brief  : Self-checking bench for alu_issue_ctrl with a transaction-level model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic        res_ready;

  wire         in_ready, res_valid, res_err, busy;
  wire  [3:0]  alu_control, res_op;
  wire  [31:0] alu_src1, alu_src2, alu_result, res_data;
  wire  [15:0] op_count;

  wire         s_in_ready, s_res_valid, s_res_err, s_busy;
  wire  [3:0]  s_alu_control, s_res_op;
  wire  [31:0] s_alu_src1, s_alu_src2, s_alu_result, s_res_data;
  wire  [1:0]  s_op_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return {31'd0, $signed(a) < $signed(b)};
      4'd4:    return {31'd0, a < b};
      4'd5:    return a & b;
      4'd6:    return ~(a | b);
      4'd7:    return a | b;
      4'd8:    return a ^ b;
      4'd9:    return b << a[4:0];
      4'd10:   return b >> a[4:0];
      4'd11:   return $signed(b) >>> a[4:0];
      4'd12:   return {b[15:0], 16'h0000};
      4'd13:   return ~(a ^ b);
      4'd14:   return a + 32'd1;
      4'd15:   return {{16{b[15]}}, b[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result   = alu_ref(alu_control, alu_src1, alu_src2);
  assign s_alu_result = alu_ref(s_alu_control, s_alu_src1, s_alu_src2);

  alu_issue_ctrl #(.CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .alu_control(alu_control),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_err(res_err), .busy(busy), .op_count(op_count)
  );

  alu_issue_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_sel(in_sel), .in_data(in_data), .alu_control(s_alu_control),
    .alu_src1(s_alu_src1), .alu_src2(s_alu_src2), .alu_result(s_alu_result),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
    .res_op(s_res_op), .res_err(s_res_err), .busy(s_busy), .op_count(s_op_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: pending op, result slot, operands and a plain count.
  logic [31:0] m_src1, m_src2, m_res;
  logic [3:0]  m_op, m_resop;
  logic        m_err, m_exec, m_done;
  int          m_count;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_src1 <= 0; m_src2 <= 0; m_res <= 0; m_op <= 0; m_resop <= 0;
      m_err <= 0; m_exec <= 0; m_done <= 0; m_count <= 0;
    end else if (m_done) begin
      if (res_ready) m_done <= 1'b0;
    end else if (m_exec) begin
      m_res   <= alu_ref(m_op, m_src1, m_src2);
      m_resop <= m_op;
      m_err   <= 1'b0;
      m_count <= m_count + 1;
      m_exec  <= 1'b0;
      m_done  <= 1'b1;
    end else if (in_valid) begin
      if (in_sel == 2'b00) m_src1 <= in_data;
      else if (in_sel == 2'b01) m_src2 <= in_data;
      else if (in_sel == 2'b10) begin
        if (in_data[3:0] == 4'd0) begin
          m_res <= 0; m_resop <= 0; m_err <= 1'b1; m_done <= 1'b1;
        end else begin
          m_op <= in_data[3:0]; m_exec <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("in_ready", 32'(in_ready), 32'(!m_exec && !m_done));
      chk("busy", 32'(busy), 32'(m_exec || m_done));
      chk("res_valid", 32'(res_valid), 32'(m_done));
      chk("alu_control", 32'(alu_control), m_exec ? 32'(m_op) : 32'd0);
      chk("alu_src1", alu_src1, m_src1);
      chk("alu_src2", alu_src2, m_src2);
      chk("res_data", res_data, m_res);
      chk("res_op", 32'(res_op), 32'(m_resop));
      chk("res_err", 32'(res_err), 32'(m_err));
      chk("op_count", 32'(op_count), 32'(m_count));
      chk("sat_op_count", 32'(s_op_count), (m_count > 3) ? 32'd3 : 32'(m_count));
    end
  end

  task automatic beat(input logic [1:0] sel, input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1; in_sel = sel; in_data = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("beat_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [3:0] opc, input logic [31:0] exp, input logic err,
                    input int lat);
    int n = 0;
    beat(2'b10, {28'hABCDEF0, opc});
    @(negedge clk);
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("lit_res_data", res_data, exp);
    chk("lit_res_op", 32'(res_op), err ? 32'd0 : 32'(opc));
    chk("lit_res_err", 32'(res_err), 32'(err));
    res_ready = 1'b1;
    @(posedge clk);
    #2;
    res_ready = 1'b0;
    @(negedge clk);
    chk("lit_in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int vcnt;
    resetn = 1'b0; in_valid = 1'b0; in_sel = 2'b00; in_data = 32'd0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);

    beat(2'b00, 32'd5); beat(2'b01, 32'd3);
    op(4'd1, 32'h00000008, 1'b0, 1);
    chk("lit_count1", 32'(op_count), 32'd1);

    beat(2'b00, 32'd3); beat(2'b01, 32'd5);
    op(4'd2, 32'hFFFFFFFE, 1'b0, 1);
    op(4'd3, 32'h00000001, 1'b0, 1);

    beat(2'b00, 32'h4); beat(2'b11, 32'h12345678); beat(2'b01, 32'h1);
    op(4'd9, 32'h00000010, 1'b0, 1);
    beat(2'b01, 32'h80000000);
    op(4'd11, 32'hF8000000, 1'b0, 1);

    op(4'd0, 32'h0, 1'b1, 0);
    chk("lit_count_illegal", 32'(op_count), 32'd5);
    chk("lit_sat_count", 32'(s_op_count), 32'd3);

    // Result held for ten cycles while a src1 write is offered.
    beat(2'b00, 32'd7); beat(2'b01, 32'd2);
    beat(2'b10, 32'd5);
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hDEAD;
    repeat (11) @(negedge clk);
    chk("hold_res_valid", 32'(res_valid), 32'd1);
    chk("hold_res_data", res_data, 32'd2);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    chk("hold_src1", alu_src1, 32'd7);
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #2 res_ready = 1'b0;
    @(negedge clk);
    chk("hold_in_ready_after", 32'(in_ready), 32'd1);

    // Consumer already ready: valid must last exactly one cycle.
    res_ready = 1'b1;
    beat(2'b10, 32'd14);
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid) vcnt++;
    end
    res_ready = 1'b0;
    chk("one_cycle_valid", 32'(vcnt), 32'd1);
    chk("inc_result_held", res_data, 32'd8);

    // Reset during EXEC drops the pending op.
    beat(2'b10, 32'd1);
    #1 resetn = 1'b0;
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_exec_res_valid", 32'(res_valid), 32'd0);
    chk("rst_exec_op_count", 32'(op_count), 32'd0);
    chk("rst_exec_src1", alu_src1, 32'd0);
    chk("rst_exec_src2", alu_src2, 32'd0);
    chk("rst_exec_in_ready", 32'(in_ready), 32'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
